// File: rtl/fir_pkg.sv
// Shared state type, accumulator sizing and saturation helper for the FIR MAC filter.
package fir_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StOut} fir_state_e;

  // Width of the sign-extended scratch word used for shift and saturation.
  localparam int unsigned WideW = 64;

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Clamp a wide signed value to the range of an out_w-bit signed word.
  function automatic logic signed [WideW-1:0] sat_to_width(input logic signed [WideW-1:0] val,
                                                           input int unsigned out_w);
    logic signed [WideW-1:0] one, hi, lo;
    one = WideW'(1);
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -(one <<< (out_w - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: range-checked write port, combinational read by tap index.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = 9,
  parameter int unsigned COEF_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_busy,
  input  logic                       i_we,
  input  logic [$clog2(TAPS)-1:0]    i_addr,
  input  logic signed [COEF_W-1:0]   i_data,
  input  logic [$clog2(TAPS)-1:0]    i_rd_addr,
  output logic signed [COEF_W-1:0]   o_rd_data,
  output logic                       o_err
);

  localparam int unsigned AddrW = $clog2(TAPS);
  localparam logic [AddrW:0] TapsLim = (AddrW + 1)'(TAPS);

  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic                     r_err;
  logic                     w_in_range;
  logic                     w_accept;

  assign w_in_range = ({1'b0, i_addr} < TapsLim);
  assign w_accept   = i_we & ~i_busy & w_in_range;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_coef[i_addr] <= i_data;
      r_err <= i_we & ~w_accept;
    end
  end

  assign o_rd_data = r_coef[i_rd_addr];
  assign o_err     = r_err;

endmodule

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter with one signed MAC, valid/ready streaming and loadable taps.
// Define FIR_SAT_EN to saturate the output (and track sat_seen) instead of wrapping.
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OUT_W  = 18,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      coef_err
);

  localparam int unsigned AddrW  = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

  fir_state_e                r_state;
  logic [AddrW-1:0]          r_k;
  logic signed [DATA_W-1:0]  r_x [TAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [OUT_W-1:0]   r_out_data;
  logic                      r_out_valid;

  logic                      w_busy;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_x;
  logic [PROD_W-1:0]         w_x_ext;
  logic [PROD_W-1:0]         w_c_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [WideW-1:0]   w_acc_wide;
  logic signed [WideW-1:0]   w_shift_wide;
  logic signed [WideW-1:0]   w_out_wide;
  logic                      w_out_load;
  logic                      w_unused;

  assign w_busy = (r_state != StIdle);

  fir_coef_bank #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W)
  ) u_coef_bank (
    .clock     (clock),
    .reset     (reset),
    .i_busy    (w_busy),
    .i_we      (coef_we),
    .i_addr    (coef_addr),
    .i_data    (coef_data),
    .i_rd_addr (r_k),
    .o_rd_data (w_coef),
    .o_err     (coef_err)
  );

  // Operands are widened to the full product width so the multiply is exact.
  assign w_x        = r_x[r_k];
  assign w_x_ext    = {{COEF_W{w_x[DATA_W-1]}}, w_x};
  assign w_c_ext    = {{DATA_W{w_coef[COEF_W-1]}}, w_coef};
  assign w_prod     = $signed(w_x_ext) * $signed(w_c_ext);
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  assign w_acc_wide   = {{(WideW - ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_shift_wide = w_acc_wide >>> SHIFT;
  assign w_out_load   = (r_state == StOut) & ~r_out_valid;

`ifdef FIR_SAT_EN
  logic sat_seen;

  assign w_out_wide = sat_to_width(w_shift_wide, OUT_W);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sat_seen <= 1'b0;
    end else if (clear) begin
      sat_seen <= 1'b0;
    end else if (w_out_load && (w_out_wide != w_shift_wide)) begin
      sat_seen <= 1'b1;
    end
  end

  assign w_unused = ^{w_out_wide[WideW-1:OUT_W], sat_seen};
`else
  assign w_out_wide = w_shift_wide;
  assign w_unused   = ^w_out_wide[WideW-1:OUT_W];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
    end else if (clear) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_x[0] <= in_data;
            for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= StMac;
          end
        end
        StMac: begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + AddrW'(1);
          if (r_k == AddrW'(TAPS - 1)) r_state <= StOut;
        end
        StOut: begin
          // First OUT cycle registers the result; afterwards it is held until taken.
          if (w_out_load) begin
            r_out_data  <= w_out_wide[OUT_W-1:0];
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Gated by reset so the block never advertises readiness while held in reset.
  assign in_ready  = (r_state == StIdle) & reset;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter: impulse table, backpressure, clear, sat/wrap, reset.
module tb_fir_mac_filter;

  localparam int unsigned TAPS   = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned COEF_W = 8;
  localparam int unsigned OUT_W  = 18;
  localparam int unsigned SHIFT  = 0;
  localparam int unsigned AW     = $clog2(TAPS);

  logic                     clock     = 1'b0;
  logic                     reset     = 1'b0;
  logic                     clear     = 1'b0;
  logic signed [DATA_W-1:0] in_data   = '0;
  logic                     in_valid  = 1'b0;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic                     coef_we   = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     coef_err;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint exp_q[$];
  longint m_coef[TAPS];
  longint m_x[TAPS];

  typedef struct {
    longint x;
    longint exp;
  } vec_t;
  vec_t vecs[10];

  always #5 clock = ~clock;

  fir_mac_filter #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint fit(input longint s);
    longint v;
    longint lim;
    v   = s >>> SHIFT;
    lim = longint'(1) << (OUT_W - 1);
`ifdef FIR_SAT_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    v = v & ((lim << 1) - 1);
    if (v >= lim) v = v - (lim << 1);
    return v;
`endif
  endfunction

  function automatic longint predict(input longint d);
    longint s;
    s = m_coef[0] * d;
    for (int k = 1; k < TAPS; k++) s += m_coef[k] * m_x[k-1];
    return fit(s);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_x();
    for (int k = 0; k < TAPS; k++) m_x[k] = 0;
  endtask

  task automatic wr(input int addr, input longint data, input bit exp_err);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = COEF_W'(data);
    tick();
    coef_we = 1'b0;
    check("coef_err pulse", longint'(coef_err), longint'(exp_err));
    if (!exp_err) m_coef[addr] = data;
    tick();
    check("coef_err one cycle", longint'(coef_err), 0);
  endtask

  task automatic send_exp(input longint d, input longint exp);
    int waited;
    waited   = 0;
    in_data  = DATA_W'(d);
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check("in_ready timeout", longint'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = d;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input longint d);
    send_exp(d, predict(d));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain queue empty", longint'(exp_q.size()), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    zero_x();
  endtask

  // Scoreboard: an output is taken at the next rising edge whenever valid and ready are high.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected output", longint'(out_valid), 0);
      else check("out_data", longint'(out_data), exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    bit     early;
    bit     stable;
    longint held;

    for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
    zero_x();

    #12;
    check("reset in_ready", longint'(in_ready), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset out_data", longint'(out_data), 0);
    check("reset coef_err", longint'(coef_err), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("in_ready after release", longint'(in_ready), 1);
    out_ready = 1'b1;

    // Impulse response through coefficients 1..TAPS, then one more zero.
    for (int k = 0; k < TAPS; k++) wr(k, k + 1, 1'b0);
    vecs[0] = '{x: 1, exp: 1};
    for (int i = 1; i < TAPS; i++) vecs[i] = '{x: 0, exp: i + 1};
    vecs[9] = '{x: 0, exp: 0};
    for (int i = 0; i < 10; i++) send_exp(vecs[i].x, vecs[i].exp);
    drain();

    // Latency and backpressure.
    out_ready = 1'b0;
    send(5);
    early = 1'b0;
    for (int i = 0; i <= TAPS; i++) begin
      if (out_valid) early = 1'b1;
      tick();
    end
    check("out_valid not early", longint'(early), 0);
    check("out_valid at latency", longint'(out_valid), 1);
    held   = out_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!out_valid || out_data != held || in_ready) stable = 1'b0;
    end
    check("backpressure hold", longint'(stable), 1);
    check("held value", held, 5);
    out_ready = 1'b1;
    tick();
    check("out_valid after handshake", longint'(out_valid), 0);
    check("in_ready after handshake", longint'(in_ready), 1);

    // Coefficient write coincident with the input handshake is used by that sample.
    coef_we   = 1'b1;
    coef_addr = AW'(1);
    coef_data = COEF_W'(20);
    m_coef[1] = 20;
    send(2);
    coef_we = 1'b0;
    check("coincident write no err", longint'(coef_err), 0);
    drain();

    // clear discards a pending output and drops a same-cycle sample.
    out_ready = 1'b0;
    send(3);
    for (int i = 0; i < 50 && !out_valid; i++) tick();
    check("out_valid before clear", longint'(out_valid), 1);
    pulse_clear();
    exp_q.delete();
    check("clear drops output", longint'(out_valid), 0);
    in_data  = DATA_W'(7);
    in_valid = 1'b1;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear drops sample", longint'(in_ready), 1);
    out_ready = 1'b1;

    // Negative values: coefficients -1, input -128.
    for (int k = 0; k < TAPS; k++) wr(k, -1, 1'b0);
    for (int i = 0; i < TAPS; i++) send_exp(-128, 128 * (i + 1));
    drain();

    // Saturation versus wrap with the largest positive operands.
    for (int k = 0; k < TAPS; k++) wr(k, 127, 1'b0);
    pulse_clear();
    for (int i = 0; i < TAPS - 1; i++) send(127);
`ifdef FIR_SAT_EN
    send_exp(127, 131071);
`else
    send_exp(127, -116983);
`endif
    drain();

    // Rejected writes: one during MAC, one out of range.
    for (int k = 0; k < TAPS; k++) wr(k, k + 1, 1'b0);
    pulse_clear();
    send(1);
    wr(0, 50, 1'b1);
    drain();
    wr(TAPS, 7, 1'b1);
    send(0);
    drain();

    // Asynchronous reset in the third MAC cycle.
    send(1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset mid-MAC out_valid", longint'(out_valid), 0);
    check("reset mid-MAC in_ready", longint'(in_ready), 0);
    exp_q.delete();
    for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
    zero_x();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("in_ready after mid-MAC reset", longint'(in_ready), 1);
    send_exp(1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
